// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receive FSM states, word-length encodings,
// and the small decode functions used by the receive framing engine.
package uart_pkg;

  // RX_BRK_WAIT is reachable only when UART_RX_BREAK_DETECT_EN is defined.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      WLS_8:   return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

  // Unused upper data bits are zero, so a full-width XOR covers only real data.
  function automatic logic parity_expected(input logic [7:0] data,
                                           input logic       eps,
                                           input logic       sp);
    if (sp)
      return ~eps;
    else if (eps)
      return ^data;
    else
      return ~(^data);
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop metastability synchronizer for asynchronous UART line inputs,
// resetting to 1 (idle level). STAGES must be at least 2.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive framing engine: votes, samples and deserialises 16550-style frames.
// Optional break detection (rx_bi plus wait-for-idle) under UART_RX_BREAK_DETECT_EN.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       rxd,
  input  logic       rx_en,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_sp,
  input  logic       voting_edge,
  input  logic       sample_edge,
  output logic       sample_clk_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_busy
);

  logic rxd_s;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rxd_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .d       (rxd),
    .q       (rxd_s)
  );

  rx_state_e   state_q, state_d;
  logic        rxd_s_d_q, rxd_s_d_d;
  logic [2:0]  vote_q, vote_d;
  logic [2:0]  vote_eff;
  logic        decision;
  logic        clr_c;

  logic [7:0]  data_q, data_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  wls_q, wls_d;
  logic        pen_q, pen_d;
  logic        eps_q, eps_d;
  logic        sp_q, sp_d;
  logic        pe_pend_q, pe_pend_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic        zero_q, zero_d;
`endif

  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_pe_q, rx_pe_d;
  logic        rx_fe_q, rx_fe_d;
  logic        rx_bi_q, rx_bi_d;

  // A vote arriving with the sample pulse is folded into that sample's decision.
  assign vote_eff = voting_edge ? {vote_q[1:0], rxd_s} : vote_q;
  assign decision = majority3(vote_eff);

  always_comb begin
    state_d    = state_q;
    rxd_s_d_d  = rxd_s;
    vote_d     = vote_q;
    clr_c      = 1'b0;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    wls_d      = wls_q;
    pen_d      = pen_q;
    eps_d      = eps_q;
    sp_d       = sp_q;
    pe_pend_d  = pe_pend_q;
`ifdef UART_RX_BREAK_DETECT_EN
    zero_d     = zero_q;
`endif
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_pe_d    = rx_pe_q;
    rx_fe_d    = rx_fe_q;
    rx_bi_d    = rx_bi_q;

    if (state_q == RX_IDLE) begin
      // Falling edge on the synchronised line arms a frame; LCR is frozen here.
      if (rx_en && rxd_s_d_q && !rxd_s) begin
        clr_c     = 1'b1;
        vote_d    = 3'b000;
        bit_cnt_d = 4'd0;
        data_d    = 8'h00;
        wls_d     = lcr_wls;
        pen_d     = lcr_pen;
        eps_d     = lcr_eps;
        sp_d      = lcr_sp;
        pe_pend_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d    = 1'b1;
`endif
        state_d   = RX_START;
      end
    end else if (!rx_en) begin
      state_d = RX_IDLE;
    end else begin
      if (voting_edge) vote_d = vote_eff;
      if (sample_edge) vote_d = {3{rxd_s}};

      case (state_q)
        RX_START: begin
          if (sample_edge) state_d = decision ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (sample_edge) begin
            data_d[bit_cnt_q[2:0]] = decision;
            bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
            if (decision) zero_d = 1'b0;
`endif
            if (bit_cnt_d == wls_to_bits(wls_q)) state_d = pen_q ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (sample_edge) begin
            pe_pend_d = (decision != parity_expected(data_q, eps_q, sp_q));
`ifdef UART_RX_BREAK_DETECT_EN
            if (decision) zero_d = 1'b0;
`endif
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (sample_edge) begin
            rx_valid_d = 1'b1;
            rx_data_d  = data_q;
            rx_pe_d    = pe_pend_q;
            rx_fe_d    = ~decision;
`ifdef UART_RX_BREAK_DETECT_EN
            rx_bi_d    = zero_q & ~decision;
            state_d    = (zero_q & ~decision) ? RX_BRK_WAIT : RX_IDLE;
`else
            rx_bi_d    = 1'b0;
            state_d    = RX_IDLE;
`endif
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        RX_BRK_WAIT: begin
          if (rxd_s) state_d = RX_IDLE;
        end
`endif
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= RX_IDLE;
      rxd_s_d_q  <= 1'b1;
      vote_q     <= 3'b111;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_bi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_s_d_q  <= rxd_s_d_d;
      vote_q     <= vote_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_pe_q    <= rx_pe_d;
      rx_fe_q    <= rx_fe_d;
      rx_bi_q    <= rx_bi_d;
    end
  end

  // Frame working registers are always loaded at start detect before use.
  always_ff @(posedge pclk) begin
    data_q    <= data_d;
    bit_cnt_q <= bit_cnt_d;
    wls_q     <= wls_d;
    pen_q     <= pen_d;
    eps_q     <= eps_d;
    sp_q      <= sp_d;
    pe_pend_q <= pe_pend_d;
`ifdef UART_RX_BREAK_DETECT_EN
    zero_q    <= zero_d;
`endif
  end

  assign sample_clk_clr = clr_c;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign rx_pe          = rx_pe_q;
  assign rx_fe          = rx_fe_q;
  assign rx_bi          = rx_bi_q;
  assign rx_busy        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer; models the bit-clock generator (16 ticks/bit,
// votes on ticks 7-9, sample on tick 9). Honours UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_deframer;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       rxd;
  logic       rx_en;
  logic [1:0] lcr_wls;
  logic       lcr_pen;
  logic       lcr_eps;
  logic       lcr_sp;
  logic       voting_edge;
  logic       sample_edge;
  logic       sample_clk_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pe;
  logic       rx_fe;
  logic       rx_bi;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int clr_cnt = 0;
  int valid_base;
  int clr_base;
  logic v10, v11;
  logic exp_bi;

  uart_rx_deframer #(.SYNC_STAGES(2)) dut (
    .pclk           (pclk),
    .presetn        (presetn),
    .rxd            (rxd),
    .rx_en          (rx_en),
    .lcr_wls        (lcr_wls),
    .lcr_pen        (lcr_pen),
    .lcr_eps        (lcr_eps),
    .lcr_sp         (lcr_sp),
    .voting_edge    (voting_edge),
    .sample_edge    (sample_edge),
    .sample_clk_clr (sample_clk_clr),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pe          (rx_pe),
    .rx_fe          (rx_fe),
    .rx_bi          (rx_bi),
    .rx_busy        (rx_busy)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rx_valid === 1'b1) valid_cnt++;
    if (sample_clk_clr === 1'b1) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period; rx_valid is captured at ticks 10/11 for latency checks.
  task automatic send_bit(input logic b);
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      if (i == 10) v10 = rx_valid;
      if (i == 11) v11 = rx_valid;
      rxd         = b;
      voting_edge = (i >= 7 && i <= 9);
      sample_edge = (i == 9);
    end
  endtask

  // Votes at ticks 7,8,9 see rxd driven at ticks 5,6,7 (two-flop synchronizer).
  task automatic send_vote(input logic b, input logic a0, input logic a1, input logic a2);
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      rxd         = (i == 5) ? a0 : (i == 6) ? a1 : (i == 7) ? a2 : b;
      voting_edge = (i >= 7 && i <= 9);
      sample_edge = (i == 9);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic pen,
                            input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pen) send_bit(par);
    send_bit(stp);
  endtask

  task automatic set_lcr(input logic [1:0] wls, input logic pen, input logic eps, input logic sp);
    lcr_wls = wls;
    lcr_pen = pen;
    lcr_eps = eps;
    lcr_sp  = sp;
  endtask

  initial begin
`ifdef UART_RX_BREAK_DETECT_EN
    exp_bi = 1'b1;
`else
    exp_bi = 1'b0;
`endif
    presetn = 1'b0; rxd = 1'b1; rx_en = 1'b1;
    voting_edge = 1'b0; sample_edge = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_flags", {rx_pe, rx_fe, rx_bi}, 3'b000);
    check("reset_busy", rx_busy, 1'b0);
    check("reset_clr", sample_clk_clr, 1'b0);
    presetn = 1'b1;
    send_bit(1'b1);

    // 8N1 0xA5
    valid_base = valid_cnt; clr_base = clr_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("8n1_valid_latency", v10, 1'b1);
    check("8n1_valid_single", v11, 1'b0);
    check("8n1_data", rx_data, 8'hA5);
    check("8n1_flags", {rx_pe, rx_fe, rx_bi}, 3'b000);
    check("8n1_valid_count", valid_cnt - valid_base, 1);
    check("8n1_clr_count", clr_cnt - clr_base, 1);
    send_bit(1'b1);

    // 7E1 0x3C: four ones, even parity bit 0; then flipped
    set_lcr(2'b10, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1);
    check("7e1_data", rx_data, 8'h3C);
    check("7e1_pe_ok", {rx_pe, rx_fe}, 2'b00);
    send_bit(1'b1);
    send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_bad_data", rx_data, 8'h3C);
    check("7e1_pe_bad", {rx_pe, rx_fe}, 2'b10);
    send_bit(1'b1);

    // 5O1 0x13: three ones, odd parity bit 0
    set_lcr(2'b00, 1'b1, 1'b0, 1'b0);
    send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1);
    check("5o1_data", rx_data, 8'h13);
    check("5o1_pe", rx_pe, 1'b0);
    send_bit(1'b1);

    // Stick parity, eps=0 -> parity bit must be 1
    set_lcr(2'b11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1);
    check("stick_pe", {rx_data, rx_pe}, {8'h00, 1'b1});
    send_bit(1'b1);

    // Glitch: two pclk low then high
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
    valid_base = valid_cnt; clr_base = clr_cnt;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      if (i == 5) check("glitch_busy_start", rx_busy, 1'b1);
      rxd         = (i < 2) ? 1'b0 : 1'b1;
      voting_edge = (i >= 7 && i <= 9);
      sample_edge = (i == 9);
    end
    @(negedge pclk);
    check("glitch_no_valid", valid_cnt - valid_base, 0);
    check("glitch_clr_once", clr_cnt - clr_base, 1);
    check("glitch_idle", rx_busy, 1'b0);
    send_bit(1'b1);

    // 8N1 0x55 with stop forced 0
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
    check("fe_data", rx_data, 8'h55);
    check("fe_flags", {rx_pe, rx_fe, rx_bi}, 3'b010);
    send_bit(1'b1);

    // Break: line low for two frame times
    valid_base = valid_cnt;
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
    check("brk_data", rx_data, 8'h00);
    check("brk_fe_bi", {rx_fe, rx_bi}, {1'b1, exp_bi});
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    check("brk_single_valid", valid_cnt - valid_base, 1);
    check("brk_hold", {rx_fe, rx_bi}, {1'b1, exp_bi});
    check("brk_busy_low_line", rx_busy, exp_bi);
    send_bit(1'b1);
    check("brk_rearm_idle", rx_busy, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    check("brk_next_frame", {rx_data, rx_pe, rx_fe, rx_bi}, {8'h81, 3'b000});
    send_bit(1'b1);

    // Majority vote: bit0 votes 0,1,0 -> 0; bit1 votes 1,0,1 -> 1
    send_bit(1'b0);
    send_vote(1'b0, 1'b0, 1'b1, 1'b0);
    send_vote(1'b1, 1'b1, 1'b0, 1'b1);
    send_bit(1'b0); send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b1);
    check("vote_data", rx_data, 8'hF2);
    send_bit(1'b1);

    // rx_en deasserted mid-DATA
    valid_base = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("abort_busy_before", rx_busy, 1'b1);
    rx_en = 1'b0;
    @(negedge pclk);
    check("abort_busy_after", rx_busy, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_bit(1'b1);
    rx_en = 1'b1;
    send_bit(1'b1);
    check("abort_no_valid", valid_cnt - valid_base, 0);
    check("abort_data_held", rx_data, 8'hF2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
